// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter over a Tx_DATA/Tx_WR strobe, paced by Tx_BUSY.
// Flags a transmitter that never acknowledges a write and records producer overflow.
module uart_tx_feeder #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  input  logic                    tx_enable,
  input  logic                    Tx_BUSY,
  output logic [7:0]              Tx_DATA,
  output logic                    Tx_WR,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    empty,
  output logic                    overflow,
  output logic                    timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_wr_q, tx_wr_d;
  logic            overflow_q, overflow_d;
  logic            timeout_err_q, timeout_err_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic            full;
  logic            fifo_empty;
  logic            pop;
  logic            push;

  assign full       = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // Pop happens exactly on the IDLE -> ISSUE edge; a full FIFO still accepts a push then.
  assign pop  = (state_q == IDLE) && !fifo_empty && tx_enable && !Tx_BUSY && !flush;
  assign push = in_valid && !flush && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (in_valid && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Transmit handshake; flush never disturbs a frame already in progress.
  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    tx_wr_d       = 1'b0;
    tx_data_d     = tx_data_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = ISSUE;
          tx_wr_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      ISSUE: begin
        state_d   = WAIT_BUSY;
        tmo_cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!Tx_BUSY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      tmo_cnt_q     <= '0;
      tx_data_q     <= 8'h00;
      tx_wr_q       <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      tmo_cnt_q     <= tmo_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_wr_q       <= tx_wr_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready    = !full;
  assign empty       = fifo_empty;
  assign fifo_count  = count_q;
  assign Tx_DATA     = tx_data_q;
  assign Tx_WR       = tx_wr_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of the feeder's observable behaviour.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       tx_enable = 1'b0;
  logic       Tx_BUSY = 1'b0;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic [3:0] fifo_count;
  logic       empty;
  logic       overflow;
  logic       timeout_err;

  uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .tx_enable(tx_enable),
    .Tx_BUSY(Tx_BUSY), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR),
    .fifo_count(fifo_count), .empty(empty),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: queued bytes plus the expected strobe/data/flags and handshake phase.
  logic [7:0] mq[$];
  logic       m_wr = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_terr = 1'b0;
  int         m_phase = 0;   // 0 free, 1 strobing, 2 awaiting busy, 3 awaiting release
  int         m_deadline = 0;

  // Recorders for literal expectations.
  logic [7:0] seen[$];
  int         wr_cyc[$];
  int         terr_first = -1;

  // Transmitter stand-in driving Tx_BUSY.
  int tx_mode = 1;   // 0 never busy, 1 busy after each strobe, 2 random noise
  int tx_lat = 1;
  int tx_len = 1;
  int tx_pend = 0;
  int tx_left = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int seen_at(input int i);
    return (i < seen.size()) ? int'(seen[i]) : -1;
  endfunction

  function automatic int wr_at(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
  endfunction

  task automatic clear_rec();
    seen.delete();
    wr_cyc.delete();
    terr_first = -1;
  endtask

  task automatic compare_model();
    chk("Tx_WR",       int'(Tx_WR),       int'(m_wr));
    chk("Tx_DATA",     int'(Tx_DATA),     int'(m_data));
    chk("fifo_count",  int'(fifo_count),  mq.size());
    chk("empty",       int'(empty),       (mq.size() == 0) ? 1 : 0);
    chk("in_ready",    int'(in_ready),    (mq.size() != DEPTH) ? 1 : 0);
    chk("overflow",    int'(overflow),    int'(m_ovf));
    chk("timeout_err", int'(timeout_err), int'(m_terr));
  endtask

  task automatic responder(output logic b);
    b = 1'b0;
    if (tx_mode == 2) begin
      b = ($urandom_range(0, 3) == 0);
    end else if (tx_left > 0) begin
      b = 1'b1;
      tx_left--;
    end else if (tx_pend > 0) begin
      tx_pend--;
      if (tx_pend == 0) begin
        b = 1'b1;
        tx_left = tx_len - 1;
      end
    end
    if (tx_mode == 1 && Tx_WR) tx_pend = tx_lat;
  endtask

  // Advance the model across one clock edge given the inputs applied for it.
  task automatic model_step(input logic v, input logic [7:0] d, input logic f,
                            input logic e, input logic b, input logic r);
    logic full, issue;
    if (r) begin
      mq.delete();
      m_wr = 1'b0; m_data = 8'h00; m_ovf = 1'b0; m_terr = 1'b0; m_phase = 0;
      return;
    end
    full  = (mq.size() == DEPTH);
    issue = (m_phase == 0) && (mq.size() > 0) && e && !b && !f;
    case (m_phase)
      1: begin m_phase = 2; m_deadline = cyc + TO; end
      2: begin
        if (b) m_phase = 3;
        else if (cyc == m_deadline) begin m_terr = 1'b1; m_phase = 0; end
      end
      3: if (!b) m_phase = 0;
      default: if (issue) m_phase = 1;
    endcase
    m_wr = issue;
    if (issue) m_data = mq.pop_front();
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (v) begin
      if (!full || issue) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f,
                      input logic e, input logic r);
    logic b;
    @(negedge clk);
    cyc++;
    compare_model();
    if (Tx_WR) begin
      seen.push_back(Tx_DATA);
      wr_cyc.push_back(cyc);
    end
    if (timeout_err && terr_first < 0) terr_first = cyc;
    responder(b);
    in_valid = v; in_data = d; flush = f; tx_enable = e; reset = r; Tx_BUSY = b;
    model_step(v, d, f, e, b, r);
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, e, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", int'(Tx_WR), 0);
    chk("rst_data", int'(Tx_DATA), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_flags", int'({overflow, timeout_err}), 0);

    // Single byte, long busy frame, second byte waits for release.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tx_mode = 1; tx_lat = 1; tx_len = 20;
    clear_rec();
    step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    pc = cyc;
    step(1'b1, 8'hB6, 1'b0, 1'b1, 1'b0);
    idle(40, 1'b1);
    chk("t1_nwr", wr_cyc.size(), 2);
    chk("t1_lat", wr_at(0), pc + 2);
    chk("t1_gap", wr_at(1) - wr_at(0), 23);
    chk("t1_b0", seen_at(0), 'hA5);
    chk("t1_b1", seen_at(1), 'hB6);

    // Fill, overflow, drain in order at minimum spacing.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_count", int'(fifo_count), 8);
    chk("t2_ready", int'(in_ready), 0);
    step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_ovf", int'(overflow), 1);
    tx_len = 1;
    clear_rec();
    idle(50, 1'b1);
    chk("t2_n", seen.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", seen_at(i), i + 1);
    for (int i = 0; i < 7; i++) chk("t2_space", wr_at(i + 1) - wr_at(i), 4);
    chk("t2_ovf_sticky", int'(overflow), 1);

    // Push and pop together while full.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t3_full", int'(fifo_count), 8);
    clear_rec();
    step(1'b1, 8'h18, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t3_count", int'(fifo_count), 8);
    chk("t3_ovf", int'(overflow), 0);
    idle(60, 1'b1);
    chk("t3_n", seen.size(), 9);
    for (int i = 0; i < 9; i++) chk("t3_order", seen_at(i), 'h10 + i);

    // Transmitter never acknowledges.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tx_mode = 0;
    clear_rec();
    step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    pc = cyc;
    step(1'b1, 8'h4D, 1'b0, 1'b1, 1'b0);
    idle(45, 1'b1);
    chk("t4_lat", wr_at(0), pc + 2);
    chk("t4_terr_at", terr_first, wr_at(0) + 17);
    chk("t4_next_wr", wr_at(1), wr_at(0) + 18);
    chk("t4_b0", seen_at(0), 'h3C);
    chk("t4_b1", seen_at(1), 'h4D);

    // Reset while strobing, with both sticky flags set.
    tx_mode = 1; tx_lat = 1; tx_len = 3;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h68, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_flags", int'({overflow, timeout_err}), 3);
    k = 0;
    while (!Tx_WR && k < 10) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      k++;
    end
    chk("t6_wr_seen", int'(Tx_WR), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6_wr", int'(Tx_WR), 0);
    chk("t6_data", int'(Tx_DATA), 0);
    chk("t6_count", int'(fifo_count), 0);
    chk("t6_flags", int'({overflow, timeout_err}), 0);

    // Flush during a frame in flight, push in the same cycle ignored.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC8, 1'b0, 1'b0, 1'b0);
    tx_len = 10;
    clear_rec();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_count", int'(fifo_count), 0);
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_busy", int'(Tx_BUSY), 1);
    idle(30, 1'b1);
    chk("t5_nwr", seen.size(), 1);
    chk("t5_b0", seen_at(0), 'hC0);
    chk("t5_hold", int'(Tx_DATA), 'hC0);
    chk("t5_terr", int'(timeout_err), 0);

    // Randomized traffic.
    for (int s = 0; s < 15; s++) begin
      tx_mode = int'($urandom_range(0, 2));
      tx_lat  = int'($urandom_range(1, 3));
      tx_len  = int'($urandom_range(1, 6));
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
             $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 399) == 0);
      end
    end
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-queueing stage placed directly upstream of the UART system's transmitter. It buffers bytes from a producer in a small FIFO. It hands them one at a time to the transmitter over the `Tx_DATA`/`Tx_WR` strobe, and uses `Tx_BUSY` to pace issue so that a new byte is never written while a frame is still in flight. It detects a transmitter that never acknowledges a write, and it records producer overflow.

## Interface

Parameters:
- `DEPTH`, default 8. FIFO entries; must be a power of two, minimum 2.
- `BUSY_TIMEOUT`, default 16. Maximum number of cycles spent waiting for `Tx_BUSY` to rise after a write; minimum 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1. System clock.
  - `reset`  in  1. Synchronous, active-high.
- Producer side:
  - `in_data`  in  8. Byte to enqueue.
  - `in_valid`  in  1. Push request.
  - `in_ready`  out  1. High when the FIFO is not full.
- Control:
  - `flush`  in  1. Synchronous FIFO clear.
  - `tx_enable`  in  1. Permits issue of new bytes.
- Transmitter side:
  - `Tx_BUSY`  in  1. Transmitter busy flag.
  - `Tx_DATA`  out  8. Byte presented to the transmitter; registered.
  - `Tx_WR`  out  1. One-cycle write strobe; registered.
- Status:
  - `fifo_count`  out  $clog2(DEPTH)+1. Current occupancy.
  - `empty`  out  1. FIFO empty.
  - `overflow`  out  1. Sticky: a push was attempted while full.
  - `timeout_err`  out  1. Sticky: `Tx_BUSY` never rose after a write.

## Operation

- FIFO:
  - Circular buffer with read and write pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
  - A push occurs when `in_valid & in_ready` and `flush` is low.
  - If `in_valid` is high while the FIFO is full, the byte is dropped and `overflow` is set.
  - A push and a pop in the same cycle leave `fifo_count` unchanged, and both complete, including when the FIFO is full.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE → ISSUE when `!empty & tx_enable & !Tx_BUSY & !flush`. On this transition edge: `Tx_DATA` ← head, `Tx_WR` ← 1, head is popped.
  - ISSUE → WAIT_BUSY unconditionally after one cycle. `Tx_WR` ← 0 and the timeout counter is cleared.
  - WAIT_BUSY → WAIT_DONE when `Tx_BUSY` is sampled high.
  - WAIT_BUSY → IDLE when the counter reaches BUSY_TIMEOUT-1 with `Tx_BUSY` still low. This sets `timeout_err`; the byte is considered consumed and is not retried.
  - WAIT_DONE → IDLE when `Tx_BUSY` is sampled low.
- `Tx_DATA` holds its value from ISSUE until the next ISSUE.
- `tx_enable` low blocks only the IDLE → ISSUE transition. A byte already issued finishes its handshake.
- `flush`:
  - Clears the pointers, `fifo_count` and `overflow` at the edge.
  - A push in the same cycle is ignored.
  - The FSM is unaffected: a handshake already in progress completes. `timeout_err` is not cleared.
- `reset` mid-operation: all state returns to its reset value at the edge, `Tx_WR` drops immediately, and FIFO contents are discarded.

## Timing

- Reset values:
  - `Tx_WR`=0, `Tx_DATA`=8'h00.
  - `in_ready`=1, `empty`=1, `fifo_count`=0.
  - `overflow`=0, `timeout_err`=0.
  - State = IDLE.
- `in_ready` and `empty` are decoded combinationally from `fifo_count`. `fifo_count` updates on the edge after the push or pop.
- Latency from push into an empty FIFO (with `tx_enable`=1 and `Tx_BUSY`=0): push captured at edge E0; `Tx_WR` is high during the cycle following edge E1, which is 2 edges after `in_valid` is sampled.
- `Tx_WR` is exactly one cycle wide.
- Minimum spacing between two `Tx_WR` pulses is 4 cycles: ISSUE, WAIT_BUSY (busy seen), WAIT_DONE (idle seen), IDLE.
- Timeout: `timeout_err` is set BUSY_TIMEOUT cycles after `Tx_WR` falls if `Tx_BUSY` stays low throughout.

## Test plan

- Reset, then push 8'hA5: `Tx_WR` pulses once, 2 edges after the push, with `Tx_DATA`=8'hA5. Model `Tx_BUSY` high for 20 cycles; no second `Tx_WR` appears before `Tx_BUSY` falls.
- Push 8'h01..8'h08 back-to-back with DEPTH=8 and `tx_enable`=0: `fifo_count`=8 and `in_ready`=0. A ninth push of 8'h09 sets `overflow`. With `tx_enable`=1, bytes 8'h01..8'h08 emerge in order and 8'h09 never appears.
- FIFO full, with a push and a pop in the same cycle: `fifo_count` stays at 8, no overflow, and the pushed byte appears last.
- `Tx_BUSY` tied low after a push of 8'h3C: `Tx_WR` pulses once. `timeout_err`=1 after 16 cycles, the FSM returns to IDLE, and the next queued byte issues.
- FIFO holds 3 bytes while a frame is in WAIT_DONE; assert `flush`: `fifo_count`=0 and `overflow` cleared. The current frame finishes and no further `Tx_WR` occurs.
- Assert `reset` while in ISSUE with `Tx_WR`=1: at the next edge `Tx_WR`=0, `Tx_DATA`=8'h00, `fifo_count`=0 and the flags are 0.
